// File: rtl/result_uart_tx.sv
// result_uart_tx -- sends a two-digit ASCII result over a UART 8N1 line.
//
// On an accepted start the block sends four characters back-to-back:
// tens digit, units digit, CR (0x0D), LF (0x0A). Any digit outside
// '0'..'9' is sent as '?' (0x3F). Each bit is held for CLKS_PER_BIT cycles.
//
// Optional feature (compile-time macro):
//   RESULT_TX_LZ_SUPPRESS_EN -- when defined, a (valid) tens digit of '0'
//   is not sent, so the sequence becomes units, CR, LF. The units digit
//   is always sent.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (2..65535)
//
// Ports:
//   clk          system clock, rising edge
//   rstn         synchronous active-low reset
//   start        request to transmit; accepted only while busy=0
//   ascii_tens   tens digit (ASCII), captured on the accepting edge
//   ascii_units  units digit (ASCII), captured on the accepting edge
//   txd          registered serial output, idle high
//   busy         high while a transmission is in progress
//   done         one-cycle pulse when the last stop bit has completed

module result_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] ascii_tens,
    input  logic [7:0] ascii_units,
    output logic       txd,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        START_BIT,
        DATA_BITS,
        STOP_BIT
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [7:0]  CHAR_CR   = 8'h0D;
    localparam logic [7:0]  CHAR_LF   = 8'h0A;
    localparam logic [7:0]  CHAR_BAD  = 8'h3F;

    state_t      state;
    logic [15:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [1:0]  char_idx;
    logic [7:0]  tens_q;
    logic [7:0]  units_q;

    // Replace anything that is not an ASCII decimal digit by '?'.
    function automatic logic [7:0] sanitize(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) ? c : CHAR_BAD;
    endfunction

    logic [7:0] tens_clean;
    logic [7:0] units_clean;
    logic [1:0] first_char;

    assign tens_clean  = sanitize(ascii_tens);
    assign units_clean = sanitize(ascii_units);

    // Leading-zero suppression simply starts the sequence at the units
    // character. The test runs on the sanitised value so only a genuine
    // '0' is skipped.
`ifdef RESULT_TX_LZ_SUPPRESS_EN
    assign first_char = (tens_clean == 8'h30) ? 2'd1 : 2'd0;
`else
    assign first_char = 2'd0;
`endif

    // Character currently on the line, selected by the character index.
    logic [7:0] cur_char;
    always_comb begin
        cur_char = CHAR_LF;
        case (char_idx)
            2'd0:    cur_char = tens_q;
            2'd1:    cur_char = units_q;
            2'd2:    cur_char = CHAR_CR;
            default: cur_char = CHAR_LF;
        endcase
    end

    logic       bit_end;
    logic [2:0] bit_next;

    assign bit_end  = (baud_cnt == BAUD_LAST);
    assign bit_next = bit_idx + 3'd1;

    // txd is loaded one cycle ahead of each bit boundary decision, i.e. it
    // is written together with the state change, so the line changes
    // exactly on bit boundaries straight from a flop.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            char_idx <= '0;
            tens_q   <= '0;
            units_q  <= '0;
            txd      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    txd      <= 1'b1;
                    busy     <= 1'b0;
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (start) begin
                        tens_q   <= tens_clean;
                        units_q  <= units_clean;
                        char_idx <= first_char;
                        state    <= START_BIT;
                        txd      <= 1'b0;
                        busy     <= 1'b1;
                    end
                end

                START_BIT: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA_BITS;
                        txd      <= cur_char[0];
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                DATA_BITS: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP_BIT;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx <= bit_next;
                            txd     <= cur_char[bit_next];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                STOP_BIT: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (char_idx == 2'd3) begin
                            // Last character finished: the done cycle is
                            // also an idle cycle, so a start here is taken.
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            txd   <= 1'b1;
                        end else begin
                            char_idx <= char_idx + 2'd1;
                            state    <= START_BIT;
                            txd      <= 1'b0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    txd   <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
